// File: rtl/usb2_ep_in_arb_if.sv
// usb2_ep_in_arb_if: commit handshake between the IN-endpoint arbiter and
// the protocol-layer IN buffer.
//   master : arbiter side (drives the commit request and its length)
//   slave  : protocol-layer side (drives ready and acknowledge)
interface usb2_ep_in_arb_if #(
   parameter int LEN_W = 10
);
   logic             buf_in_ready;
   logic             buf_in_commit;
   logic [LEN_W-1:0] buf_in_commit_len;
   logic             buf_in_commit_ack;

   modport master (
      input  buf_in_ready,
      input  buf_in_commit_ack,
      output buf_in_commit,
      output buf_in_commit_len
   );

   modport slave (
      output buf_in_ready,
      output buf_in_commit_ack,
      input  buf_in_commit,
      input  buf_in_commit_len
   );
endinterface

// File: rtl/usb2_ep_in_arb.sv
// usb2_ep_in_arb: round-robin arbiter that lets NUM_CH IN-endpoint channels
// share one protocol-layer IN buffer. A grant latches the channel index and
// its length, holds the commit request until acknowledged, then spends one
// RELEASE cycle so that a requester's stale commit level is never regranted.
//
// Optional feature: define USB2_ARB_TIMEOUT_EN to add an ack watchdog that
// abandons a commit after TIMEOUT_CYCLES unacknowledged ISSUE cycles and
// pulses err_timeout. Without it, ISSUE waits indefinitely.
module usb2_ep_in_arb #(
   parameter  int NUM_CH         = 4,
   parameter  int LEN_W          = 10,
   parameter  int TIMEOUT_CYCLES = 4096,
   localparam int SEL_W          = $clog2(NUM_CH)
) (
   input  logic                    ext_clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       ch_commit,
   input  logic [NUM_CH*LEN_W-1:0] ch_commit_len,
   output logic [NUM_CH-1:0]       ch_commit_ack,
   usb2_ep_in_arb_if.master        buf_if,
   output logic [SEL_W-1:0]        arb_sel,
   output logic                    arb_busy,
   output logic                    err_timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    last_grant_q, last_grant_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [NUM_CH-1:0]   ack_q, ack_d;
   logic [SEL_W-1:0]    grant_idx;
   logic [SEL_W-1:0]    scan_idx;

`ifdef USB2_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
`endif

   // Round-robin pick: first requester found searching upward from last_grant+1.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      grant_idx = last_grant_q;
      scan_idx  = '0;
      // Scan from farthest to nearest so the nearest requester is written last.
      for (int i = NUM_CH; i >= 1; i--) begin
         scan_idx = SEL_W'((int'(last_grant_q) + i) % NUM_CH);
         if (ch_commit[scan_idx]) begin
            grant_idx = scan_idx;
         end
      end
   end

   // Next-state and registered-output computation for the IDLE/ISSUE/RELEASE FSM.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      sel_d        = sel_q;
      len_d        = len_q;
      ack_d        = '0;
`ifdef USB2_ARB_TIMEOUT_EN
      cnt_d        = cnt_q;
      err_d        = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (buf_if.buf_in_ready && (|ch_commit)) begin
               state_d = ISSUE;
               sel_d   = grant_idx;
               len_d   = ch_commit_len[grant_idx*LEN_W +: LEN_W];
`ifdef USB2_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ISSUE: begin
            // An ack on the watchdog's final cycle still completes normally.
            if (buf_if.buf_in_commit_ack) begin
               ack_d[sel_q] = 1'b1;
               state_d      = RELEASE;
            end
`ifdef USB2_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         RELEASE: begin
            last_grant_d = sel_q;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge ext_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= SEL_W'(NUM_CH - 1);
         sel_q        <= '0;
         len_q        <= '0;
         ack_q        <= '0;
`ifdef USB2_ARB_TIMEOUT_EN
         cnt_q        <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         sel_q        <= sel_d;
         len_q        <= len_d;
         ack_q        <= ack_d;
`ifdef USB2_ARB_TIMEOUT_EN
         cnt_q        <= cnt_d;
         err_q        <= err_d;
`endif
      end
   end

   assign buf_if.buf_in_commit     = (state_q == ISSUE);
   assign buf_if.buf_in_commit_len = len_q;
   assign arb_sel                  = sel_q;
   assign arb_busy                 = (state_q != IDLE);
   assign ch_commit_ack            = ack_q;
`ifdef USB2_ARB_TIMEOUT_EN
   assign err_timeout              = err_q;
`else
   assign err_timeout              = 1'b0;
`endif

endmodule

// File: tb/tb_usb2_ep_in_arb.sv
// tb_usb2_ep_in_arb: scoreboard bench for usb2_ep_in_arb. Expected grants
// (channel, length) are queued when requests are driven and popped when the
// arbiter raises buf_in_commit. Build with USB2_ARB_TIMEOUT_EN to add the
// watchdog scenario (TIMEOUT_CYCLES=16).
module tb_usb2_ep_in_arb;
   localparam int NUM_CH         = 4;
   localparam int LEN_W          = 10;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int SEL_W          = $clog2(NUM_CH);

   typedef struct {
      int ch;
      int len;
   } exp_t;

   logic                    ext_clk;
   logic                    reset;
   logic [NUM_CH-1:0]       ch_commit;
   logic [NUM_CH*LEN_W-1:0] ch_commit_len;
   logic [NUM_CH-1:0]       ch_commit_ack;
   logic [SEL_W-1:0]        arb_sel;
   logic                    arb_busy;
   logic                    err_timeout;

   usb2_ep_in_arb_if #(.LEN_W(LEN_W)) buf_if ();

   usb2_ep_in_arb #(
      .NUM_CH         (NUM_CH),
      .LEN_W          (LEN_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .ext_clk       (ext_clk),
      .reset         (reset),
      .ch_commit     (ch_commit),
      .ch_commit_len (ch_commit_len),
      .ch_commit_ack (ch_commit_ack),
      .buf_if        (buf_if.master),
      .arb_sel       (arb_sel),
      .arb_busy      (arb_busy),
      .err_timeout   (err_timeout)
   );

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   initial begin
      ext_clk = 1'b0;
      forever #5 ext_clk = ~ext_clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench still running at %0t", $time);
      $fatal(1, "bench time limit");
   end

   task automatic set_len(input int ch, input int v);
      ch_commit_len[ch*LEN_W +: LEN_W] = LEN_W'(v);
   endtask

   task automatic do_reset();
      reset                    = 1'b1;
      ch_commit                = '0;
      buf_if.buf_in_ready      = 1'b1;
      buf_if.buf_in_commit_ack = 1'b0;
      repeat (2) @(negedge ext_clk);
      reset = 1'b0;
      sb.delete();
   endtask

   // Consume one grant from the scoreboard: wait for buf_in_commit, compare
   // channel/length, hold for 'delay' cycles, acknowledge, observe the pulse.
   task automatic serve(input string tag, input int delay, input bit drop);
      bit               ok;
      bit               stable;
      exp_t             e;
      logic [SEL_W-1:0] s0;
      logic [LEN_W-1:0] l0;
      ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         if (buf_if.buf_in_commit === 1'b1) ok = 1'b1;
         else @(negedge ext_clk);
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_wait: buf_in_commit not seen within 64 cycles", tag);
         return;
      end
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL %s_sb: unexpected commit sel=%0d, scoreboard empty", tag, arb_sel);
         return;
      end
      e = sb.pop_front();
      if (arb_sel !== SEL_W'(e.ch) || buf_if.buf_in_commit_len !== LEN_W'(e.len)) begin
         failures++;
         $display("FAIL %s_grant: sel=%0d len=%0d, expected sel=%0d len=%0d",
                  tag, arb_sel, buf_if.buf_in_commit_len, e.ch, e.len);
      end
      s0     = arb_sel;
      l0     = buf_if.buf_in_commit_len;
      stable = 1'b1;
      for (int i = 0; i < delay; i++) begin
         @(negedge ext_clk);
         if (buf_if.buf_in_commit !== 1'b1 || arb_sel !== s0 ||
             buf_if.buf_in_commit_len !== l0 || ch_commit_ack !== '0) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL %s_hold: commit/sel/len not stable during ISSUE, now commit=%b sel=%0d len=%0d",
                  tag, buf_if.buf_in_commit, arb_sel, buf_if.buf_in_commit_len);
      end
      buf_if.buf_in_commit_ack = 1'b1;
      @(negedge ext_clk);
      buf_if.buf_in_commit_ack = 1'b0;
      if (drop) ch_commit[e.ch] = 1'b0;
      checks++;
      if (ch_commit_ack !== (NUM_CH'(1) << e.ch) || buf_if.buf_in_commit !== 1'b0 ||
          err_timeout !== 1'b0 || arb_busy !== 1'b1) begin
         failures++;
         $display("FAIL %s_ack: ack=%b commit=%b err=%b busy=%b, expected ack=%b commit=0 err=0 busy=1",
                  tag, ch_commit_ack, buf_if.buf_in_commit, err_timeout, arb_busy,
                  NUM_CH'(1) << e.ch);
      end
      @(negedge ext_clk);
      checks++;
      if (ch_commit_ack !== '0 || arb_busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_ack_end: ack=%b busy=%b, expected ack=0 busy=0", tag, ch_commit_ack, arb_busy);
      end
   endtask

   task automatic test_reset();
      reset                    = 1'b1;
      ch_commit                = '1;
      ch_commit_len            = '1;
      buf_if.buf_in_ready      = 1'b1;
      buf_if.buf_in_commit_ack = 1'b0;
      repeat (3) @(negedge ext_clk);
      checks++;
      if (buf_if.buf_in_commit !== 1'b0 || arb_busy !== 1'b0 || arb_sel !== '0 ||
          buf_if.buf_in_commit_len !== '0 || ch_commit_ack !== '0 || err_timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: commit=%b busy=%b sel=%0d len=%0d ack=%b err=%b, expected all 0",
                  buf_if.buf_in_commit, arb_busy, arb_sel, buf_if.buf_in_commit_len,
                  ch_commit_ack, err_timeout);
      end
      ch_commit = '0;
      reset     = 1'b0;
      @(negedge ext_clk);
   endtask

   task automatic test_single();
      do_reset();
      set_len(0, 64);
      ch_commit = NUM_CH'(4'b0001);
      sb.push_back('{0, 64});
      @(negedge ext_clk);
      checks++;
      if (buf_if.buf_in_commit !== 1'b1) begin
         failures++;
         $display("FAIL single_latency: commit=%b one cycle after request, expected 1", buf_if.buf_in_commit);
      end
      serve("single", 3, 1'b1);
   endtask

   task automatic test_round_robin();
      do_reset();
      set_len(0, 0);
      set_len(1, 101);
      set_len(2, 102);
      set_len(3, 1023);
      for (int pass = 0; pass < 2; pass++) begin
         ch_commit = '1;
         for (int c = 0; c < NUM_CH; c++) sb.push_back('{c, (c == 0) ? 0 : (c == 3) ? 1023 : 100 + c});
         for (int c = 0; c < NUM_CH; c++) serve($sformatf("rr_p%0d_%0d", pass, c), 1 + c, 1'b1);
      end
   endtask

   task automatic test_holdoff();
      bit bad;
      do_reset();
      buf_if.buf_in_ready      = 1'b0;
      buf_if.buf_in_commit_ack = 1'b1;  // stray ack while IDLE must be ignored
      set_len(2, 33);
      ch_commit = NUM_CH'(4'b0100);
      bad = 1'b0;
      repeat (20) begin
         @(negedge ext_clk);
         if (buf_if.buf_in_commit !== 1'b0 || ch_commit_ack !== '0 || arb_busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL holdoff_idle: commit=%b ack=%b busy=%b while ready=0, expected 0",
                  buf_if.buf_in_commit, ch_commit_ack, arb_busy);
      end
      buf_if.buf_in_commit_ack = 1'b0;
      buf_if.buf_in_ready      = 1'b1;
      sb.push_back('{2, 33});
      @(negedge ext_clk);
      checks++;
      if (buf_if.buf_in_commit !== 1'b1 || arb_sel !== SEL_W'(2)) begin
         failures++;
         $display("FAIL holdoff_release: commit=%b sel=%0d, expected commit=1 sel=2",
                  buf_if.buf_in_commit, arb_sel);
      end
      serve("holdoff", 2, 1'b1);
   endtask

   task automatic test_abort_immunity();
      do_reset();
      set_len(1, 512);
      ch_commit = NUM_CH'(4'b0010);
      sb.push_back('{1, 512});
      @(negedge ext_clk);
      ch_commit = '0;
      set_len(1, 7);
      repeat (3) @(negedge ext_clk);
      checks++;
      if (buf_if.buf_in_commit !== 1'b1 || buf_if.buf_in_commit_len !== LEN_W'(512)) begin
         failures++;
         $display("FAIL abort_hold: commit=%b len=%0d after drop, expected commit=1 len=512",
                  buf_if.buf_in_commit, buf_if.buf_in_commit_len);
      end
      serve("abort", 2, 1'b0);
   endtask

   task automatic test_reset_in_issue();
      do_reset();
      set_len(0, 11);
      set_len(2, 5);
      ch_commit = NUM_CH'(4'b0100);
      @(negedge ext_clk);
      reset = 1'b1;
      @(negedge ext_clk);
      checks++;
      if (buf_if.buf_in_commit !== 1'b0 || arb_busy !== 1'b0 || ch_commit_ack !== '0 ||
          arb_sel !== '0) begin
         failures++;
         $display("FAIL reset_issue: commit=%b busy=%b ack=%b sel=%0d, expected all 0",
                  buf_if.buf_in_commit, arb_busy, ch_commit_ack, arb_sel);
      end
      reset     = 1'b0;
      ch_commit = NUM_CH'(4'b0101);
      sb.push_back('{0, 11});
      sb.push_back('{2, 5});
      serve("reset_issue_ch0", 1, 1'b1);
      serve("reset_issue_ch2", 1, 1'b1);
   endtask

`ifdef USB2_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      bit seen_ack;
      do_reset();
      set_len(0, 77);
      set_len(1, 88);
      ch_commit = NUM_CH'(4'b0011);
      @(negedge ext_clk);
      checks++;
      if (buf_if.buf_in_commit !== 1'b1 || arb_sel !== '0) begin
         failures++;
         $display("FAIL timeout_grant: commit=%b sel=%0d, expected commit=1 sel=0",
                  buf_if.buf_in_commit, arb_sel);
      end
      n        = 0;
      seen_ack = 1'b0;
      while (err_timeout !== 1'b1 && n < 40) begin
         @(negedge ext_clk);
         n++;
         if (ch_commit_ack !== '0) seen_ack = 1'b1;
      end
      checks++;
      if (n != TIMEOUT_CYCLES) begin
         failures++;
         $display("FAIL timeout_cycles: err_timeout after %0d cycles, expected %0d", n, TIMEOUT_CYCLES);
      end
      checks++;
      if (buf_if.buf_in_commit !== 1'b0 || seen_ack) begin
         failures++;
         $display("FAIL timeout_abort: commit=%b ack_seen=%b, expected commit=0 ack_seen=0",
                  buf_if.buf_in_commit, seen_ack);
      end
      @(negedge ext_clk);
      checks++;
      if (err_timeout !== 1'b0) begin
         failures++;
         $display("FAIL timeout_pulse: err_timeout=%b one cycle later, expected 0", err_timeout);
      end
      // Ack lands on the cycle the watchdog would fire: must complete normally.
      sb.push_back('{1, 88});
      serve("timeout_next", TIMEOUT_CYCLES - 1, 1'b1);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_holdoff();
      test_abort_immunity();
      test_reset_in_issue();
`ifdef USB2_ARB_TIMEOUT_EN
      test_timeout();
`endif
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d expected grants never observed", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/usb2_ep_in_arb.md
USB2_EP_IN_ARB -- requirements
Module: usb2_ep_in_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of external IN-endpoint channels, legal range 2..16.
REQ-002 SHALL have parameter LEN_W, default 10: commit length width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: ack watchdog limit, legal range 2..65535.
REQ-004 SHALL have derived localparam SEL_W = ceil(log2(NUM_CH)).
REQ-005 SHALL have port ext_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ch_commit, input, NUM_CH bits: per-channel commit request level.
REQ-008 SHALL have port ch_commit_len, input, NUM_CH*LEN_W bits: channel i length at bits [i*LEN_W +: LEN_W].
REQ-009 SHALL have port ch_commit_ack, output, NUM_CH bits: per-channel one-cycle completion pulse.
REQ-010 SHALL have port buf_in_ready, input, 1 bit: the protocol-layer IN buffer accepts a commit.
REQ-011 SHALL have port buf_in_commit, output, 1 bit: commit request to the protocol layer.
REQ-012 SHALL have port buf_in_commit_len, output, LEN_W bits: length of the granted commit.
REQ-013 SHALL have port buf_in_commit_ack, input, 1 bit: protocol-layer commit acknowledge.
REQ-014 SHALL have port arb_sel, output, SEL_W bits: channel owning the buffer, used to steer the external data mux.
REQ-015 SHALL have port arb_busy, output, 1 bit: high in every state other than IDLE.
REQ-016 SHALL have port err_timeout, output, 1 bit: one-cycle watchdog pulse.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE and RELEASE.
REQ-018 In IDLE, when buf_in_ready=1 and ch_commit is nonzero, the block SHALL grant the first requesting channel searching upward from last_grant+1, modulo NUM_CH.
REQ-019 On a grant, the block SHALL register arb_sel and that channel's length, and enter ISSUE.
REQ-020 buf_in_commit SHALL be 1 exactly while the FSM is in ISSUE.
REQ-021 A request seen in IDLE at cycle N SHALL produce buf_in_commit=1 at cycle N+1.
REQ-022 buf_in_commit_len and arb_sel SHALL stay stable from grant until the FSM returns to IDLE.
REQ-023 When buf_in_commit_ack=1 in ISSUE at cycle M, ch_commit_ack[arb_sel] SHALL be 1 for cycle M+1 only, buf_in_commit SHALL be 0 at M+1, and the FSM SHALL enter RELEASE.
REQ-024 RELEASE SHALL last exactly one cycle, SHALL set last_grant to arb_sel, and SHALL return to IDLE.
REQ-025 A requester SHALL drop ch_commit on the cycle after its ack; RELEASE exists so that the stale level is never regranted.
REQ-026 A channel deasserting ch_commit during ISSUE SHALL NOT abort the commit; the latched length completes.
REQ-027 Changes to ch_commit_len after grant SHALL be ignored.
REQ-028 A length of 0 SHALL be legal and forwarded unchanged.
REQ-029 buf_in_ready=0 in IDLE SHALL hold off all grants; buf_in_ready is not sampled in ISSUE or RELEASE.
REQ-030 buf_in_commit_ack outside ISSUE SHALL be ignored.
REQ-031 Simultaneous requests SHALL be served one per grant in round-robin order, with no starvation: the worst-case wait is NUM_CH-1 grants.
REQ-032 At most one bit of ch_commit_ack SHALL be set in any cycle.

Reset
REQ-033 While reset=1 at a clock edge, the block SHALL enter IDLE with last_grant=NUM_CH-1, so that channel 0 wins first.
REQ-034 Reset SHALL drive to 0: arb_sel, buf_in_commit, buf_in_commit_len, ch_commit_ack, arb_busy, err_timeout and the watchdog counter.
REQ-035 Reset during ISSUE SHALL abandon the commit with no ch_commit_ack, and buf_in_commit SHALL be 0 on the next cycle.

Configuration
REQ-036 With macro USB2_ARB_TIMEOUT_EN defined, a counter SHALL run in ISSUE, clear on entry to ISSUE, and count each ISSUE cycle without ack.
REQ-037 With USB2_ARB_TIMEOUT_EN defined, at count TIMEOUT_CYCLES the block SHALL pulse err_timeout for 1 cycle, drop buf_in_commit, send no ch_commit_ack, and go to RELEASE, where last_grant advances.
REQ-038 With USB2_ARB_TIMEOUT_EN defined, an ack arriving on the same cycle as the timeout SHALL take precedence as a normal completion.
REQ-039 Without USB2_ARB_TIMEOUT_EN, ISSUE SHALL wait indefinitely, err_timeout SHALL be tied to 0, and no counter SHALL be synthesised.

Verification
REQ-040 Single request: ch_commit=0001, len0=64, ready=1, ack 3 cycles after commit -> buf_in_commit 1 cycle after request, len=64, sel=0, ch_commit_ack=0001 for one cycle.
REQ-041 Round-robin: ch_commit=1111 held with each requester dropping after its ack -> grant order 0,1,2,3; a second pass after re-request starts at 0.
REQ-042 Holdoff: ready=0 with ch_commit=0100 for 20 cycles -> no buf_in_commit; ready=1 -> commit with sel=2 on the next cycle.
REQ-043 Abort immunity: ch_commit[1] dropped and len1 changed from 512 to 7 during ISSUE -> buf_in_commit_len stays 512, ack still returned to channel 1.
REQ-044 Timeout (macro on, TIMEOUT_CYCLES=16): no ack -> err_timeout pulse after 16 ISSUE cycles, no ch_commit_ack, next pending channel granted.
REQ-045 Reset in ISSUE: reset=1 for 1 cycle -> buf_in_commit=0 next cycle, arb_busy=0, the next grant goes to channel 0.
